// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address split, frame layout
// and fetch FSM state encoding for the default 16-frame geometry.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IDX_W   = $clog2(ICACHE_NFRAMES);
    localparam int ICACHE_TAG_W   = 30 - ICACHE_IDX_W;

    // Fetch address viewed as {tag, frame index, byte offset}
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // One cache frame: a single instruction word plus its tag and valid bit
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-block instruction cache between the fetch stage and
// the memory arbiter. Hits return combinationally; a miss runs a single-word
// read to memory, fills the frame, then the retried request hits.
module icache_fetch
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES,
    parameter int TAG_W   = 30 - $clog2(NFRAMES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [15:0] misscnt
);

    localparam int IDX_W = $clog2(NFRAMES);

    // Frame layout sized from this instance's geometry
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } frame_t;

    frame_t            frames_r [NFRAMES];
    icache_state_t     state_r;
    icache_state_t     next_state_s;
    word_t             miss_addr_r;
    logic [15:0]       misscnt_r;

    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [TAG_W-1:0]  fill_tag_s;
    logic [IDX_W-1:0]  fill_idx_s;
    logic              miss_s;
    logic              fill_s;

    assign req_tag_s  = imemaddr[31:IDX_W+2];
    assign req_idx_s  = imemaddr[IDX_W+1:2];
    assign fill_tag_s = miss_addr_r[31:IDX_W+2];
    assign fill_idx_s = miss_addr_r[IDX_W+1:2];
    assign misscnt    = misscnt_r;

    // Hit detection, memory handshake outputs and next-state selection
    always_comb begin
        ihit         = 1'b0;
        imemload     = 32'h0000_0000;
        iREN         = 1'b0;
        iaddr        = 32'h0000_0000;
        miss_s       = 1'b0;
        fill_s       = 1'b0;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                ihit = imemREN & frames_r[req_idx_s].valid &
                       (frames_r[req_idx_s].tag == req_tag_s) & ~iflush;
                if (ihit) begin
                    imemload = frames_r[req_idx_s].data;
                end else begin
                    imemload = 32'h0000_0000;
                end
                miss_s = imemREN & ~ihit & ~iflush;
                if (miss_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_r;
                // A started fill always runs to completion, whatever the PC does
                if (!iwait) begin
                    fill_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    fill_s       = 1'b0;
                    next_state_s = FETCH;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, miss address, miss counter and frame array updates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            miss_addr_r <= 32'h0000_0000;
            misscnt_r   <= 16'h0000;
            for (int i = 0; i < NFRAMES; i++) begin
                frames_r[i].valid <= 1'b0;
            end
        end else begin
            state_r <= next_state_s;
            if (miss_s) begin
                // Byte offset is forced to zero so the memory read is word aligned
                miss_addr_r <= {imemaddr[31:2], imemaddr[1:0] & 2'b00};
                if (misscnt_r != 16'hFFFF) begin
                    misscnt_r <= misscnt_r + 16'd1;
                end
            end
            // A flush wins over a fill landing on the same edge
            if (iflush) begin
                for (int i = 0; i < NFRAMES; i++) begin
                    frames_r[i].valid <= 1'b0;
                end
            end else if (fill_s) begin
                frames_r[fill_idx_s] <= '{valid: 1'b1, tag: fill_tag_s, data: iload};
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: a hand-built vector table for the
// directed scenarios, hand-written reset and saturation sequences, and a
// randomized phase checked against a transaction-level cache model.
module tb_icache_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [15:0] misscnt;

    int n_pass  = 0;
    int n_total = 0;

    icache_fetch dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .misscnt  (misscnt)
    );

    always #5 CLK = ~CLK;

    // Memory contents: every word is a fixed function of its address
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h2001_0004;
    endfunction

    assign iload = mem_fn(iaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ren, input logic [31:0] a, input logic fl, input logic wt);
        imemREN  = ren;
        imemaddr = a;
        iflush   = fl;
        iwait    = wt;
    endtask

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        flush;
        logic        wt;
        logic        hit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] ia;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic ren, input logic [31:0] addr, input logic flush,
                               input logic wt, input logic hit, input logic [31:0] load,
                               input logic iren, input logic [31:0] ia, input logic [15:0] cnt);
        vec_t r;
        r.ren = ren; r.addr = addr; r.flush = flush; r.wt = wt;
        r.hit = hit; r.load = load; r.iren = iren; r.ia = ia; r.cnt = cnt;
        return r;
    endfunction

    // Transaction-level model: each frame remembers which word address it holds
    logic        m_vld  [16];
    logic [31:0] m_addr [16];
    logic        m_busy;
    logic [31:0] m_pend;
    logic [15:0] m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_vld[i]  = 1'b0;
            m_addr[i] = 32'h0;
        end
        m_busy = 1'b0;
        m_pend = 32'h0;
        m_cnt  = 16'h0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    initial begin
        logic        e_hit;
        logic [31:0] wa;
        logic [3:0]  ix;

        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        do_reset();

        // Reset state
        #4;
        chk("reset_ihit", {31'h0, ihit}, 32'h0);
        chk("reset_imemload", imemload, 32'h0);
        chk("reset_iREN", {31'h0, iREN}, 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        chk("reset_misscnt", {16'h0, misscnt}, 32'h0);
        next_cycle();

        // Directed table: one row per cycle, outputs sampled mid-cycle
        //                ren   addr          fl    wt    hit   load          iren  iaddr         cnt
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd0));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        16'd1));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h2001_0004, 1'b0, 32'h0,        16'd1));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h2001_0004, 1'b0, 32'h0,        16'd1));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd1));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,        16'd2));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h2001_0000, 1'b0, 32'h0,        16'd2));
        vecs.push_back(v(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd2));
        vecs.push_back(v(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h44,       16'd3));
        vecs.push_back(v(1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 32'h2001_0040, 1'b0, 32'h0,        16'd3));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd3));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,        16'd4));
        vecs.push_back(v(1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd4));
        vecs.push_back(v(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h2001_0000, 1'b0, 32'h0,        16'd4));
        // wait states while the PC moves away
        vecs.push_back(v(1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        16'd4));
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h8,        16'd5));
        vecs.push_back(v(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        16'd5));
        vecs.push_back(v(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h2001_000C, 1'b0, 32'h0,        16'd5));
        vecs.push_back(v(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd5));
        vecs.push_back(v(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,      16'd6));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd6));
        // flush on the completing fill edge
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        16'd7));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd7));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        16'd8));
        vecs.push_back(v(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd8));
        vecs.push_back(v(1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        16'd9));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h2001_0004, 1'b0, 32'h0,        16'd9));
        // flush during a waiting fill: fill is still written
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd9));
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,        16'd10));
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,        16'd10));
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'h2001_0008, 1'b0, 32'h0,        16'd10));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd10));
        vecs.push_back(v(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        16'd11));
        // flush in IDLE suppresses the hit and the miss
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd11));
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        16'd11));
        vecs.push_back(v(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,        16'd12));

        foreach (vecs[r]) begin
            drive(vecs[r].ren, vecs[r].addr, vecs[r].flush, vecs[r].wt);
            #4;
            chk($sformatf("vec%0d_ihit", r), {31'h0, ihit}, {31'h0, vecs[r].hit});
            chk($sformatf("vec%0d_imemload", r), imemload, vecs[r].load);
            chk($sformatf("vec%0d_iREN", r), {31'h0, iREN}, {31'h0, vecs[r].iren});
            chk($sformatf("vec%0d_iaddr", r), iaddr, vecs[r].ia);
            chk($sformatf("vec%0d_misscnt", r), {16'h0, misscnt}, {16'h0, vecs[r].cnt});
            next_cycle();
        end

        // Reset asserted in the middle of a waiting fill
        drive(1'b1, 32'h0000_0020, 1'b0, 1'b1);
        next_cycle();
        #2;
        chk("midfetch_iREN_before", {31'h0, iREN}, 32'h1);
        RST = 1'b1;
        #1;
        chk("midfetch_iREN_async", {31'h0, iREN}, 32'h0);
        chk("midfetch_iaddr_async", iaddr, 32'h0);
        next_cycle();
        RST = 1'b0;
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        #4;
        chk("postrst_misscnt", {16'h0, misscnt}, 32'h0);
        chk("postrst_addr0_miss", {31'h0, ihit}, 32'h0);
        next_cycle();
        #4;
        chk("postrst_fetch_iaddr", iaddr, 32'h0);
        chk("postrst_misscnt1", {16'h0, misscnt}, 32'h1);
        next_cycle();
        drive(1'b1, 32'h0000_000C, 1'b0, 1'b0);
        #4;
        chk("postrst_addrC_miss", {31'h0, ihit}, 32'h0);
        next_cycle();

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            wa = {22'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'b00};
            drive($urandom_range(0, 3) != 0, wa | 32'($urandom_range(0, 3)),
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4);
            #4;
            ix = wa[5:2];
            if (!m_busy) begin
                e_hit = imemREN && m_vld[ix] && (m_addr[ix] == wa) && !iflush;
                chk("rnd_ihit", {31'h0, ihit}, {31'h0, e_hit});
                chk("rnd_imemload", imemload, e_hit ? mem_fn(wa) : 32'h0);
                chk("rnd_iREN", {31'h0, iREN}, 32'h0);
                chk("rnd_iaddr", iaddr, 32'h0);
            end else begin
                e_hit = 1'b0;
                chk("rnd_ihit", {31'h0, ihit}, 32'h0);
                chk("rnd_imemload", imemload, 32'h0);
                chk("rnd_iREN", {31'h0, iREN}, 32'h1);
                chk("rnd_iaddr", iaddr, m_pend);
            end
            chk("rnd_misscnt", {16'h0, misscnt}, {16'h0, m_cnt});
            // advance the model across the coming edge
            if (!m_busy) begin
                if (imemREN && !e_hit && !iflush) begin
                    m_busy = 1'b1;
                    m_pend = wa;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end else if (!iwait) begin
                m_busy = 1'b0;
                m_vld[m_pend[5:2]]  = 1'b1;
                m_addr[m_pend[5:2]] = m_pend;
            end
            if (iflush) begin
                for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
            end
            next_cycle();
        end

        // Counter saturation, preloaded near the limit
        do_reset();
        #2;
        force dut.misscnt_r = 16'hFFFD;
        #1;
        release dut.misscnt_r;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
            next_cycle();
            #4;
            chk($sformatf("sat_misscnt%0d", k), {16'h0, misscnt},
                (k == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
